adder_nbit_serial: RTL and testbench
====================================

Name: adder_nbit_serial

Overview:
- Multi-cycle, chunk-serial successor to the combinational n-bit adder with carry out.
- Processes CHUNK bits per clock through a CHUNK-wide chain of adder_1bit cells, with a registered carry between chunks. This trades latency for area in PIM datapaths.
- Adds a carry-in, a subtract mode, signed-overflow reporting and valid/ready handshakes on both sides.
- Sits between the PIM operand fetch and the result writeback.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- IMPL_TYPE, 0, passed unchanged to every adder_1bit instance.
- NCHUNK (localparam) = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; ignored when Sub=1.
- Sub  input  1  0: A+B+Cin; 1: A+~B+1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
- Ovf  output  1  signed overflow.

Behaviour:
- State machine has three states: IDLE, RUN, DONE.
- Reset:
  - Forces IDLE, chunk counter 0, carry reg 0.
  - Sum=0, Cout=0, Ovf=0, out_valid=0.
  - Asynchronous: takes effect immediately and aborts any operation in flight. No partial result ever appears.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready.
- Accept occurs when in_valid & in_ready at an edge:
  - Latch A and ~B (Sub) or B (else) into operand regs.
  - Set carry reg = Sub ? 1 : Cin; counter = 0; go to RUN.
  - Inputs may change freely after accept.
- RUN, each cycle:
  - Feed operand chunk [cnt*CHUNK +: CHUNK] and the carry reg into the CHUNK-bit adder_1bit chain.
  - Write the chunk sum into the Sum reg at the same bit slice and store the chain carry-out in the carry reg.
  - cnt increments.
  - On the cycle cnt==NCHUNK-1, also set Cout = final carry and Ovf = (carry into MSB) ^ (carry out of MSB), then go to DONE.
- Latency: accept at edge k → out_valid high after edge k+NCHUNK.
- DONE:
  - out_valid=1. Sum, Cout and Ovf are held stable while out_ready=0, for any duration.
  - out_ready=1 & in_valid=1: result retires and new operands are accepted at the same edge → RUN (back-to-back, one idle-free handoff).
  - out_ready=1 & in_valid=0: → IDLE, out_valid=0.
- Sum, Cout and Ovf change only during RUN; they keep their last value in IDLE.
- Sum bits from a previous result may be visible mid-RUN. Consumers use outputs only while out_valid=1.
- Width rule: arithmetic is modulo 2^WIDTH; the carry out of the MSB goes to Cout only.
- CHUNK==WIDTH (NCHUNK=1): RUN lasts exactly one cycle.
- Counter width: clog2(NCHUNK), minimum 1 bit.
- in_valid while busy (RUN, or DONE without out_ready) is ignored, with no side effects.

Test Plan:
- Add with signed overflow (WIDTH=8, CHUNK=4): A=0x7F, B=0x01, Cin=0, Sub=0, accepted at edge k → out_valid after edge k+2, Sum=0x80, Cout=0, Ovf=1.
- Wrap and carry-in: A=0xFF, B=0x00, Cin=1 → Sum=0x00, Cout=1, Ovf=0. Then A=0x12, B=0x34, Cin=1 → Sum=0x47, Cout=0, Ovf=0.
- Subtract:
  - A=0x05, B=0x07, Sub=1, Cin=1 (ignored) → Sum=0xFE, Cout=0, Ovf=0.
  - A=0x80, B=0x01, Sub=1 → Sum=0x7F, Cout=1, Ovf=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, Sum stable, in_ready=0, extra in_valid pulses ignored.
  - Raise out_ready with in_valid=1 → new op accepted that edge, next out_valid after 2 more edges.
- Reset mid-RUN: assert rst one cycle after accept → out_valid=0, Sum=0, in_ready=1 immediately. After release, A=0x01, B=0x01 → Sum=0x02.
- Parameter sweep (WIDTH=32) with random operands against a reference model:
  - CHUNK=32: latency 1.
  - CHUNK=1: latency 32.
  - CHUNK=8: latency 4.
  - All configurations must match Sum/Cout/Ovf exactly.

Source files
------------

// File: rtl/adder_nbit_serial_if.sv
// Operand/result handshake bundle for the chunk-serial adder.
// The slave modport is the adder's view; the master modport is the operand source and result consumer.
interface adder_nbit_serial_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/adder_nbit_serial.sv
// Chunk-serial WIDTH-bit adder/subtractor: CHUNK bits per clock through an adder_1bit chain,
// with the carry registered between chunks, plus signed-overflow reporting and valid/ready handshakes.

module adder_1bit #(
    parameter int unsigned IMPL_TYPE = 0
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    generate
        if (IMPL_TYPE == 0) begin : g_gate
            assign s    = a ^ b ^ cin;
            assign cout = (a & b) | (cin & (a ^ b));
        end else begin : g_beh
            assign {cout, s} = 2'(a) + 2'(b) + 2'(cin);
        end
    endgenerate
endmodule

module adder_nbit_serial #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CHUNK     = 4,
    parameter int unsigned IMPL_TYPE = 0
) (
    input logic                 clk,
    input logic                 rst,
    adder_nbit_serial_if.slave  bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   op_a, op_b, sum_q;
    logic               carry, cout_q, ovf_q, out_valid_q;
    logic [CNT_W-1:0]   cnt;
    logic               accept, last;
    logic [CHUNK-1:0]   chunk_a, chunk_b, chunk_sum;
    logic [CHUNK:0]     c;

    assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign last          = (cnt == CNT_W'(NCHUNK - 1));
    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.Ovf       = ovf_q;

    // Ripple chain over the current chunk, seeded by the registered inter-chunk carry
    assign chunk_a = op_a[int'(cnt)*CHUNK +: CHUNK];
    assign chunk_b = op_b[int'(cnt)*CHUNK +: CHUNK];
    assign c[0]    = carry;

    genvar i;
    generate
        for (i = 0; i < CHUNK; i++) begin : g_bit
            adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_fa (
                .a    (chunk_a[i]),
                .b    (chunk_b[i]),
                .cin  (c[i]),
                .s    (chunk_sum[i]),
                .cout (c[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nx;
            out_valid_q <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = bus.in_valid ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture on accept; one chunk of sum/carry per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.A;
            op_b  <= bus.Sub ? ~bus.B : bus.B;
            carry <= bus.Sub ? 1'b1 : bus.Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum_q[int'(cnt)*CHUNK +: CHUNK] <= chunk_sum;
            carry <= c[CHUNK];
            cnt   <= last ? '0 : cnt + CNT_W'(1);
            if (last) begin
                cout_q <= c[CHUNK];
                ovf_q  <= c[CHUNK-1] ^ c[CHUNK];
            end
        end
    end
endmodule

// File: tb/tb_adder_nbit_serial.sv
// Self-checking bench for adder_nbit_serial: directed 8-bit scenarios plus a WIDTH=32 chunk sweep
// against an integer-arithmetic reference model.
module tb_adder_nbit_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    adder_nbit_serial_if #(.WIDTH(8)) if8 ();
    adder_nbit_serial #(.WIDTH(8), .CHUNK(4), .IMPL_TYPE(0)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    logic        s_valid, s_ready, s_cin, s_sub;
    logic [31:0] s_a, s_b;

    adder_nbit_serial_if #(.WIDTH(32)) ifw ();
    adder_nbit_serial_if #(.WIDTH(32)) ifb ();
    adder_nbit_serial_if #(.WIDTH(32)) ifc ();
    adder_nbit_serial #(.WIDTH(32), .CHUNK(32), .IMPL_TYPE(0)) dutw (.clk(clk), .rst(rst), .bus(ifw));
    adder_nbit_serial #(.WIDTH(32), .CHUNK(1),  .IMPL_TYPE(1)) dutb (.clk(clk), .rst(rst), .bus(ifb));
    adder_nbit_serial #(.WIDTH(32), .CHUNK(8),  .IMPL_TYPE(0)) dutc (.clk(clk), .rst(rst), .bus(ifc));

    assign {ifw.in_valid, ifw.out_ready, ifw.Cin, ifw.Sub, ifw.A, ifw.B} = {s_valid, s_ready, s_cin, s_sub, s_a, s_b};
    assign {ifb.in_valid, ifb.out_ready, ifb.Cin, ifb.Sub, ifb.A, ifb.B} = {s_valid, s_ready, s_cin, s_sub, s_a, s_b};
    assign {ifc.in_valid, ifc.out_ready, ifc.Cin, ifc.Sub, ifc.A, ifc.B} = {s_valid, s_ready, s_cin, s_sub, s_a, s_b};

    function automatic void model8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                                   output logic [7:0] s, output logic co, output logic ov);
        int ua, ub, sa, sb, r, sr;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        if (sub) begin
            r = ua - ub; sr = sa - sb; co = (ua >= ub);
        end else begin
            r = ua + ub + int'(cin); sr = sa + sb + int'(cin); co = (r > 255);
        end
        s  = 8'(r);
        ov = (sr > 127) || (sr < -128);
    endfunction

    function automatic void model32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                                    output logic [31:0] s, output logic co, output logic ov);
        longint ua, ub, sa, sb, r, sr;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        if (sub) begin
            r = ua - ub; sr = sa - sb; co = (ua >= ub);
        end else begin
            r = ua + ub + longint'(cin); sr = sa + sb + longint'(cin); co = (r > 64'hFFFF_FFFF);
        end
        s  = 32'(r);
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    // Accept one 8-bit op (caller is one #1 past an edge) and wait, bounded, for out_valid.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                           output logic [7:0] s, output logic co, output logic ov, output int lat);
        if8.A = a; if8.B = b; if8.Cin = cin; if8.Sub = sub; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        if8.A = 8'($urandom); if8.B = 8'($urandom); if8.Cin = 1'($urandom);
        lat = 0;
        while (!if8.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = if8.Sum; co = if8.Cout; ov = if8.Ovf;
    endtask

    task automatic retire8();
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({if8.out_valid, if8.Sum, if8.Cout, if8.Ovf, if8.in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset got ov=%b sum=%h c=%b o=%b rdy=%b exp 0/00/0/0/1",
                     if8.out_valid, if8.Sum, if8.Cout, if8.Ovf, if8.in_ready);
        end
        checks++;
        if ({ifw.out_valid, ifb.out_valid, ifc.out_valid, ifb.Sum} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL reset32 got valids=%b%b%b sum=%h exp 000/0", ifw.out_valid, ifb.out_valid, ifc.out_valid, ifb.Sum);
        end
    endtask

    task automatic test_add_ovf();
        logic [7:0] s; logic co, ov; int lat;
        run_op8(8'h7F, 8'h01, 1'b0, 1'b0, s, co, ov, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL add_ovf latency got %0d exp 2", lat); end
        checks++;
        if ({s, co, ov} !== {8'h80, 1'b0, 1'b1}) begin
            errors++; $display("FAIL add_ovf got sum=%h c=%b o=%b exp 80/0/1", s, co, ov);
        end
        retire8();
    endtask

    task automatic test_wrap_cin();
        logic [7:0] s; logic co, ov; int lat;
        run_op8(8'hFF, 8'h00, 1'b1, 1'b0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h00, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wrap got sum=%h c=%b o=%b exp 00/1/0", s, co, ov);
        end
        retire8();
        run_op8(8'h12, 8'h34, 1'b1, 1'b0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h47, 1'b0, 1'b0}) begin
            errors++; $display("FAIL cin got sum=%h c=%b o=%b exp 47/0/0", s, co, ov);
        end
        retire8();
    endtask

    task automatic test_subtract();
        logic [7:0] s; logic co, ov; int lat;
        run_op8(8'h05, 8'h07, 1'b1, 1'b1, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'hFE, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_borrow got sum=%h c=%b o=%b exp FE/0/0", s, co, ov);
        end
        retire8();
        run_op8(8'h80, 8'h01, 1'b0, 1'b1, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h7F, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sub_ovf got sum=%h c=%b o=%b exp 7F/1/1", s, co, ov);
        end
        retire8();
    endtask

    task automatic test_back_to_back();
        logic [7:0] s, s0; logic co, ov; int lat;
        run_op8(8'h3C, 8'h21, 1'b0, 1'b0, s0, co, ov, lat);
        for (int i = 0; i < 5; i++) begin
            if8.A = 8'($urandom); if8.B = 8'($urandom); if8.in_valid = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({if8.out_valid, if8.Sum, if8.in_ready} !== {1'b1, 8'h5D, 1'b0}) begin
                errors++; $display("FAIL hold cyc%0d got ov=%b sum=%h rdy=%b exp 1/5D/0", i, if8.out_valid, if8.Sum, if8.in_ready);
            end
        end
        if8.A = 8'h10; if8.B = 8'h20; if8.Cin = 1'b0; if8.Sub = 1'b0; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
        #1;
        checks++;
        if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready got %b exp 1", if8.in_ready); end
        @(posedge clk); #1;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0;
        checks++;
        if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL b2b handoff out_valid got %b exp 0", if8.out_valid); end
        lat = 0;
        while (!if8.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        s = if8.Sum;
        checks++;
        if (lat !== 2 || s !== 8'h30) begin errors++; $display("FAIL b2b got lat=%0d sum=%h exp 2/30", lat, s); end
        retire8();
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s; logic co, ov; int lat;
        if8.A = 8'h55; if8.B = 8'h66; if8.Cin = 1'b0; if8.Sub = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({if8.out_valid, if8.Sum, if8.in_ready} !== {1'b0, 8'h00, 1'b1}) begin
            errors++; $display("FAIL rst_mid got ov=%b sum=%h rdy=%b exp 0/00/1", if8.out_valid, if8.Sum, if8.in_ready);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid partial got out_valid=%b exp 0", if8.out_valid); end
        run_op8(8'h01, 8'h01, 1'b0, 1'b0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h02, 1'b0, 1'b0} || lat !== 2) begin
            errors++; $display("FAIL rst_after got sum=%h c=%b o=%b lat=%0d exp 02/0/0/2", s, co, ov, lat);
        end
        retire8();
    endtask

    task automatic test_random8();
        logic [7:0] a, b, s, es; logic cin, sub, co, ov, eco, eov; int lat;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            model8(a, b, cin, sub, es, eco, eov);
            run_op8(a, b, cin, sub, s, co, ov, lat);
            checks++;
            if ({s, co, ov} !== {es, eco, eov} || lat !== 2) begin
                errors++; $display("FAIL rand8 a=%h b=%h cin=%b sub=%b got %h/%b/%b lat=%0d exp %h/%b/%b lat=2",
                                   a, b, cin, sub, s, co, ov, lat, es, eco, eov);
            end
            retire8();
        end
    endtask

    task automatic test_sweep32();
        logic [31:0] a, b, es; logic cin, sub, eco, eov;
        int lw, lb, lc;
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            if (i == 0) begin a = 32'h7FFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0; end
            if (i == 1) begin a = 32'h8000_0000; b = 32'h1; sub = 1'b1; end
            if (i == 2) begin a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; sub = 1'b0; end
            model32(a, b, cin, sub, es, eco, eov);
            s_a = a; s_b = b; s_cin = cin; s_sub = sub; s_valid = 1'b1;
            @(posedge clk); #1;
            s_valid = 1'b0; s_a = $urandom; s_b = $urandom;
            lw = -1; lb = -1; lc = -1;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                @(posedge clk); #1;
                if (ifw.out_valid && lw < 0) lw = cyc;
                if (ifb.out_valid && lb < 0) lb = cyc;
                if (ifc.out_valid && lc < 0) lc = cyc;
            end
            checks++;
            if (lw !== 1 || lb !== 32 || lc !== 4) begin
                errors++; $display("FAIL sweep lat op%0d got w=%0d b=%0d c=%0d exp 1/32/4", i, lw, lb, lc);
            end
            checks++;
            if ({ifw.Sum, ifw.Cout, ifw.Ovf} !== {es, eco, eov}) begin
                errors++; $display("FAIL sweep chunk32 op%0d got %h/%b/%b exp %h/%b/%b", i, ifw.Sum, ifw.Cout, ifw.Ovf, es, eco, eov);
            end
            checks++;
            if ({ifb.Sum, ifb.Cout, ifb.Ovf} !== {es, eco, eov}) begin
                errors++; $display("FAIL sweep chunk1 op%0d got %h/%b/%b exp %h/%b/%b", i, ifb.Sum, ifb.Cout, ifb.Ovf, es, eco, eov);
            end
            checks++;
            if ({ifc.Sum, ifc.Cout, ifc.Ovf} !== {es, eco, eov}) begin
                errors++; $display("FAIL sweep chunk8 op%0d got %h/%b/%b exp %h/%b/%b", i, ifc.Sum, ifc.Cout, ifc.Ovf, es, eco, eov);
            end
            s_ready = 1'b1;
            @(posedge clk); #1;
            s_ready = 1'b0;
        end
    endtask

    initial begin
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.A = '0; if8.B = '0; if8.Cin = 1'b0; if8.Sub = 1'b0;
        s_valid = 1'b0; s_ready = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
        #12 rst = 1'b0;
        test_reset();
        test_add_ovf();
        test_wrap_cin();
        test_subtract();
        test_back_to_back();
        test_reset_mid_run();
        test_random8();
        test_sweep32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
